// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared constants and FSM encoding for the nibble-serial CLA adder sequencer.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result valid-ready bus between producer, adder sequencer and consumer.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_seq_adder_ctrl_cla.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module CLA_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is flattened from cin so no ripple chain forms inside the slice.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[3:0];
  assign cout = w_c[4];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle, LSB first, through a single shared CLA slice.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_seq_adder_ctrl_if.slave  bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_carry;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [WIDTH-1:0]      r_acc;
  logic [WIDTH-1:0]      r_sum;
  logic                  r_cout;
  logic                  r_ovf;
  logic                  r_valid;

  logic [NIBBLE_W-1:0]   w_a_nib;
  logic [NIBBLE_W-1:0]   w_b_nib;
  logic [NIBBLE_W-1:0]   w_s;
  logic                  w_c;
  logic [WIDTH-1:0]      w_acc_next;

  assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  CLA_adder u_cla (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // Working accumulator is separate from r_sum so the visible result holds until the next DONE.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_idx*NIBBLE_W +: NIBBLE_W] = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_carry <= bus.in_cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_c;
          if (r_idx == LAST_IDX) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_c;
            r_ovf   <= ovf_f(r_a[WIDTH-1], r_b[WIDTH-1], w_s[NIBBLE_W-1]);
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for the nibble-serial adder at WIDTH=16 and WIDTH=4.
module tb_cla_seq_adder_ctrl;
  import cla_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   t_acc16;
  int   t_acc4;

  logic [17:0] q16[$];
  logic [5:0]  q4[$];

  cla_seq_adder_ctrl_if #(.WIDTH(16)) bus16 ();
  cla_seq_adder_ctrl_if #(.WIDTH(4))  bus4 ();

  cla_seq_adder_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cla_seq_adder_ctrl #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    logic        ov;
    t  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ov = (a[15] == b[15]) && (t[15] != a[15]);
    return {ov, t[16], t[15:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    ov = (a[3] == b[3]) && (t[3] != a[3]);
    return {ov, t[4], t[3:0]};
  endfunction

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic cin, input bit push);
    int n = 0;
    @(negedge clk);
    bus16.in_a = a; bus16.in_b = b; bus16.in_cin = cin; bus16.in_valid = 1'b1;
    while (!bus16.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready16", {31'd0, bus16.in_ready}, 32'd1);
    if (push) q16.push_back(model16(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    t_acc16 = cyc;
    bus16.in_valid = 1'b0;
    bus16.in_a = ~a; bus16.in_b = ~b; bus16.in_cin = ~cin;
  endtask

  task automatic recv16(input int hold, input bit poke);
    int n = 0;
    logic [17:0] e;
    while (!bus16.out_valid && n < 100) begin @(negedge clk); n++; end
    chk("out_valid16", {31'd0, bus16.out_valid}, 32'd1);
    chk("latency16", cyc - t_acc16, 16 / NIBBLE_W);
    if (q16.size() == 0) begin
      chk("sb_empty16", 32'd0, 32'd1);
      e = '0;
    end else e = q16.pop_front();
    chk("sum16", {16'd0, bus16.out_sum}, {16'd0, e[15:0]});
    chk("cout16", {31'd0, bus16.out_cout}, {31'd0, e[16]});
    chk("ovf16", {31'd0, bus16.out_ovf}, {31'd0, e[17]});
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus16.in_valid = 1'b1; bus16.in_a = 16'hAAAA; bus16.in_b = 16'h5555; bus16.in_cin = 1'b1;
      end
      @(negedge clk);
      chk("hold_valid16", {31'd0, bus16.out_valid}, 32'd1);
      chk("hold_sum16", {16'd0, bus16.out_sum}, {16'd0, e[15:0]});
      chk("hold_flags16", {30'd0, bus16.out_ovf, bus16.out_cout}, {30'd0, e[17:16]});
      chk("hold_in_ready16", {31'd0, bus16.in_ready}, 32'd0);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.out_ready = 1'b0;
    chk("valid_fall16", {31'd0, bus16.out_valid}, 32'd0);
    chk("idle_ready16", {31'd0, bus16.in_ready}, 32'd1);
    chk("keep_sum16", {16'd0, bus16.out_sum}, {16'd0, e[15:0]});
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int n = 0;
    logic [5:0] e;
    @(negedge clk);
    bus4.in_a = a; bus4.in_b = b; bus4.in_cin = cin; bus4.in_valid = 1'b1;
    chk("in_ready4", {31'd0, bus4.in_ready}, 32'd1);
    q4.push_back(model4(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    t_acc4 = cyc;
    bus4.in_valid = 1'b0;
    bus4.in_a = ~a; bus4.in_b = ~b;
    while (!bus4.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("out_valid4", {31'd0, bus4.out_valid}, 32'd1);
    chk("latency4", cyc - t_acc4, 4 / NIBBLE_W);
    e = q4.pop_front();
    chk("sum4", {28'd0, bus4.out_sum}, {28'd0, e[3:0]});
    chk("cout4", {31'd0, bus4.out_cout}, {31'd0, e[4]});
    chk("ovf4", {31'd0, bus4.out_ovf}, {31'd0, e[5]});
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    chk("valid_fall4", {31'd0, bus4.out_valid}, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; t_acc16 = 0; t_acc4 = 0;
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid = 1'b0;  bus4.in_a = '0;  bus4.in_b = '0;  bus4.in_cin = 1'b0;  bus4.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, bus16.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, bus16.out_sum}, 32'd0);
    chk("rst_flags", {30'd0, bus16.out_ovf, bus16.out_cout}, 32'd0);
    chk("rst_in_ready", {31'd0, bus16.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, bus16.in_ready}, 32'd1);

    drive16(16'h1234, 16'h5678, 1'b0, 1'b1); recv16(0, 1'b0);
    drive16(16'hFFFF, 16'h0001, 1'b0, 1'b1); recv16(0, 1'b0);
    drive16(16'h7FFF, 16'h0001, 1'b0, 1'b1); recv16(0, 1'b0);
    drive16(16'h8000, 16'h8000, 1'b1, 1'b1); recv16(0, 1'b0);
    drive16(16'hA5C3, 16'h3C5A, 1'b1, 1'b1); recv16(0, 1'b0);

    drive16(16'h0F0F, 16'h00F1, 1'b0, 1'b1); recv16(5, 1'b1);
    drive16(16'h0006, 16'h0008, 1'b0, 1'b1); recv16(0, 1'b0);

    drive16(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {31'd0, bus16.out_valid}, 32'd0);
    chk("abort_sum", {16'd0, bus16.out_sum}, 32'd0);
    chk("abort_in_ready", {31'd0, bus16.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", {31'd0, bus16.in_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("abort_no_result", {31'd0, bus16.out_valid}, 32'd0);
    drive16(16'h000C, 16'h0009, 1'b1, 1'b1); recv16(0, 1'b0);

    op4(4'd7, 4'd11, 1'b0);
    op4(4'd13, 4'd4, 1'b1);
    op4(4'd8, 4'd8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
